dmem_arbiter: RTL

Sequences and shares the single data-memory port between two requesters: the core load/store path, driven by the decoded mem_wren and load signals, and a debug/loader port. The block latches one request at a time and holds it stable on a ready/ack memory interface with variable latency. It stalls the core PC while a core access is outstanding. It sits between the LSU address/data path and the data memory.

---
 rtl/dmem_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one ready/ack memory port between the core
// load/store path and a debug/loader port, with starvation guard and timeout.
module dmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DBG_MAX_WAIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [31:0]       i_core_wdata,
  input  logic [3:0]        i_core_bmask,
  output logic              o_core_stall,
  output logic              o_core_done,
  output logic [31:0]       o_core_rdata,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [31:0]       i_dbg_wdata,
  output logic              o_dbg_gnt,
  output logic              o_dbg_rvalid,
  output logic [31:0]       o_dbg_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_err
);

  // state  | meaning
  // S_IDLE | arbitrate between core and debug, latch the winner's payload
  // S_BUSY | memory request held with stable payload, waiting for ack/timeout
  // S_RESP | single completion cycle toward the owner, no arbitration

  localparam int SW = (DBG_MAX_WAIT > 0) ? $clog2(DBG_MAX_WAIT + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_dbg_q;
  logic [SW-1:0]     starv_q;
  logic [TW-1:0]     tmo_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_bmask_q;
  logic              core_done_q;
  logic              dbg_rvalid_q;
  logic              err_q;
  logic [31:0]       core_rdata_q;
  logic [31:0]       dbg_rdata_q;

  logic              grant_core;
  logic              grant_dbg;
  logic              to_resp;
  logic              timed_out;
  logic [31:0]       resp_data;

  always_comb begin
    state_d    = state_q;
    grant_core = 1'b0;
    grant_dbg  = 1'b0;
    to_resp    = 1'b0;
    timed_out  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_dbg_req && (starv_q == SW'(DBG_MAX_WAIT))) grant_dbg = 1'b1;
        else if (i_core_req)                             grant_core = 1'b1;
        else if (i_dbg_req)                              grant_dbg = 1'b1;
        if (grant_core || grant_dbg) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (i_mem_ack) begin
          to_resp = 1'b1;
        end else if (tmo_q == '0) begin
          to_resp   = 1'b1;
          timed_out = 1'b1;
        end
        if (to_resp) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_data = i_mem_ack ? i_mem_rdata : 32'hDEAD_BEEF;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      owner_dbg_q  <= 1'b0;
      starv_q      <= '0;
      tmo_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_bmask_q  <= '0;
      core_done_q  <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      err_q        <= 1'b0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      core_done_q  <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      err_q        <= 1'b0;

      if (grant_core || grant_dbg) begin
        owner_dbg_q <= grant_dbg;
        mem_req_q   <= 1'b1;
        tmo_q       <= TW'(TIMEOUT - 1);
        if (grant_dbg) begin
          mem_we_q    <= i_dbg_we;
          mem_addr_q  <= i_dbg_addr;
          mem_wdata_q <= i_dbg_wdata;
          mem_bmask_q <= 4'hF;
        end else begin
          mem_we_q    <= i_core_we;
          mem_addr_q  <= i_core_addr;
          mem_wdata_q <= i_core_wdata;
          mem_bmask_q <= i_core_bmask;
        end
      end

      // Starvation guard only counts core wins that actually made debug wait.
      if (grant_dbg)
        starv_q <= '0;
      else if (grant_core && i_dbg_req && (starv_q != SW'(DBG_MAX_WAIT)))
        starv_q <= starv_q + 1'b1;

      if ((state_q == S_BUSY) && !to_resp)
        tmo_q <= tmo_q - 1'b1;

      if (to_resp) begin
        mem_req_q <= 1'b0;
        err_q     <= timed_out;
        if (owner_dbg_q) begin
          dbg_rvalid_q <= 1'b1;
          dbg_rdata_q  <= resp_data;
        end else begin
          core_done_q  <= 1'b1;
          core_rdata_q <= resp_data;
        end
      end
    end
  end

  assign o_dbg_gnt    = grant_dbg & ~i_reset;
  assign o_core_done  = core_done_q;
  assign o_core_rdata = core_rdata_q;
  assign o_core_stall = i_core_req & ~core_done_q;
  assign o_dbg_rvalid = dbg_rvalid_q;
  assign o_dbg_rdata  = dbg_rdata_q;
  assign o_mem_req    = mem_req_q;
  assign o_mem_we     = mem_we_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_mem_bmask  = mem_bmask_q;
  assign o_err        = err_q;

endmodule
